// File: rtl/vga_timing_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_timing_engine                                                        |
// | VGA raster timing with pixel-source latency compensation, sync/blank     |
// | generation and line/frame pulses. Define VGA_TE_TEST_PATTERN_EN to add   |
// | the pattern_sel input and an eight-bar colour test pattern.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vga_timing_engine #(
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int COLOR_W         = 2,
    parameter int PIX_DIV         = 1,
    parameter int PIPE_LAT        = 1,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
`ifdef VGA_TE_TEST_PATTERN_EN
    input  logic               pattern_sel,
`endif
    input  logic [COLOR_W-1:0] red_pixel_in,
    input  logic [COLOR_W-1:0] green_pixel_in,
    input  logic [COLOR_W-1:0] blue_pixel_in,
    output logic [9:0]         xcoor,
    output logic [9:0]         ycoor,
    output logic               hs,
    output logic               vs,
    output logic               display_active,
    output logic [COLOR_W-1:0] red_pixel_out,
    output logic [COLOR_W-1:0] green_pixel_out,
    output logic [COLOR_W-1:0] blue_pixel_out,
    output logic               line_start,
    output logic               frame_start
);

    localparam int         c_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         c_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] c_H_LAST   = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST   = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] c_V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] c_HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] c_VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam int         c_DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(PIX_DIV - 1);
    localparam logic       c_SYNC_LOW = 1'(SYNC_ACTIVE_LOW);

    logic [c_DIV_W-1:0] r_div;
    logic [9:0]         r_h;
    logic [9:0]         r_v;
    logic               r_act;
    logic               r_hsy;
    logic               r_vsy;
    logic [COLOR_W-1:0] r_red;
    logic [COLOR_W-1:0] r_green;
    logic [COLOR_W-1:0] r_blue;
    logic               r_line_start;
    logic               r_frame_start;

    logic               w_tick;
    logic               w_h_wrap;
    logic               w_v_wrap;
    logic               w_act;
    logic               w_hsy;
    logic               w_vsy;
    logic               w_act_nxt;
    logic               w_hsy_nxt;
    logic               w_vsy_nxt;
    logic [COLOR_W-1:0] w_src_red;
    logic [COLOR_W-1:0] w_src_green;
    logic [COLOR_W-1:0] w_src_blue;

    assign w_tick   = enable && (r_div == c_DIV_MAX);
    assign w_h_wrap = (r_h == c_H_LAST);
    assign w_v_wrap = (r_v == c_V_LAST);

    assign w_act = (r_h < c_H_ACT) && (r_v < c_V_ACT);
    assign w_hsy = (r_h >= c_HS_BEG) && (r_h < c_HS_END);
    assign w_vsy = (r_v >= c_VS_BEG) && (r_v < c_VS_END);

`ifdef VGA_TE_TEST_PATTERN_EN
    logic [9:0] w_h_nxt;
    logic [9:0] w_bar;
    assign w_bar = w_h_nxt / 10'(H_ACTIVE / 8);
`endif

    // The final delay stage is the output register itself; the pre-stages
    // below supply the value that stage will load on the next tick.
    generate
        if (PIPE_LAT == 1) begin : g_lat1
            assign w_act_nxt = w_act;
            assign w_hsy_nxt = w_hsy;
            assign w_vsy_nxt = w_vsy;
`ifdef VGA_TE_TEST_PATTERN_EN
            assign w_h_nxt   = r_h;
`endif
        end else begin : g_latn
            logic [PIPE_LAT-2:0] r_act_p;
            logic [PIPE_LAT-2:0] r_hsy_p;
            logic [PIPE_LAT-2:0] r_vsy_p;
`ifdef VGA_TE_TEST_PATTERN_EN
            logic [9:0]          r_h_p [PIPE_LAT-1];
`endif
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_act_p <= '0;
                    r_hsy_p <= '0;
                    r_vsy_p <= '0;
`ifdef VGA_TE_TEST_PATTERN_EN
                    for (int i = 0; i < PIPE_LAT - 1; i++) begin
                        r_h_p[i] <= '0;
                    end
`endif
                end else if (w_tick) begin
                    for (int i = PIPE_LAT - 2; i > 0; i--) begin
                        r_act_p[i] <= r_act_p[i-1];
                        r_hsy_p[i] <= r_hsy_p[i-1];
                        r_vsy_p[i] <= r_vsy_p[i-1];
`ifdef VGA_TE_TEST_PATTERN_EN
                        r_h_p[i]   <= r_h_p[i-1];
`endif
                    end
                    r_act_p[0] <= w_act;
                    r_hsy_p[0] <= w_hsy;
                    r_vsy_p[0] <= w_vsy;
`ifdef VGA_TE_TEST_PATTERN_EN
                    r_h_p[0]   <= r_h;
`endif
                end
            end
            assign w_act_nxt = r_act_p[PIPE_LAT-2];
            assign w_hsy_nxt = r_hsy_p[PIPE_LAT-2];
            assign w_vsy_nxt = r_vsy_p[PIPE_LAT-2];
`ifdef VGA_TE_TEST_PATTERN_EN
            assign w_h_nxt   = r_h_p[PIPE_LAT-2];
`endif
        end
    endgenerate

    always_comb begin
        w_src_red   = red_pixel_in;
        w_src_green = green_pixel_in;
        w_src_blue  = blue_pixel_in;
`ifdef VGA_TE_TEST_PATTERN_EN
        if (pattern_sel) begin
            w_src_red   = {COLOR_W{w_bar[0]}};
            w_src_green = {COLOR_W{w_bar[1]}};
            w_src_blue  = {COLOR_W{w_bar[2]}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div         <= '0;
            r_h           <= '0;
            r_v           <= '0;
            r_act         <= 1'b0;
            r_hsy         <= 1'b0;
            r_vsy         <= 1'b0;
            r_red         <= '0;
            r_green       <= '0;
            r_blue        <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= w_tick && w_h_wrap;
            r_frame_start <= w_tick && w_h_wrap && w_v_wrap;
            if (enable) begin
                r_div <= (r_div == c_DIV_MAX) ? '0 : r_div + 1'b1;
            end
            if (w_tick) begin
                if (w_h_wrap) begin
                    r_h <= '0;
                    r_v <= w_v_wrap ? '0 : r_v + 10'd1;
                end else begin
                    r_h <= r_h + 10'd1;
                end
                r_act   <= w_act_nxt;
                r_hsy   <= w_hsy_nxt;
                r_vsy   <= w_vsy_nxt;
                r_red   <= w_act_nxt ? w_src_red   : '0;
                r_green <= w_act_nxt ? w_src_green : '0;
                r_blue  <= w_act_nxt ? w_src_blue  : '0;
            end
        end
    end

    assign xcoor           = r_h;
    assign ycoor           = r_v;
    assign hs              = r_hsy ^ c_SYNC_LOW;
    assign vs              = r_vsy ^ c_SYNC_LOW;
    assign display_active  = r_act;
    assign red_pixel_out   = r_red;
    assign green_pixel_out = r_green;
    assign blue_pixel_out  = r_blue;
    assign line_start      = r_line_start;
    assign frame_start     = r_frame_start;

endmodule
`default_nettype wire
